// File: rtl/sample_output_serializer_pkg.sv
// sample_output_serializer_pkg
// Shared definitions for the sample output serializer slice: serial frame
// geometry, the sample word type and small helpers that map a frame slot
// to its word-select level and to the sample bit carried in that slot.
// No ports (package).
package sample_output_serializer_pkg;

  localparam int SLOTS_PER_FRAME = 32;
  localparam int WS_HIGH_FIRST   = 15;
  localparam int WS_HIGH_LAST    = 30;
  localparam int SAMPLE_WIDTH    = 16;
  localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [SLOT_W-1:0]              slot_t;

  // Word select leads the MSB by one slot, so it is high from the last
  // left-channel slot up to the second-to-last right-channel slot.
  function automatic logic ws_for_slot(input slot_t s);
    return (s >= slot_t'(WS_HIGH_FIRST)) && (s <= slot_t'(WS_HIGH_LAST));
  endfunction

  // Both channel halves send bits 15..0, so the bit index is 15 minus
  // the slot position within its half.
  function automatic logic [3:0] bit_index(input slot_t s);
    return ~s[3:0];
  endfunction

endpackage

// File: rtl/sample_output_serializer_fifo.sv
// sample_fifo
// Synchronous sample FIFO with asynchronous active-high reset.
// A pop on a non-empty FIFO frees a slot in the same cycle, so a push
// while full succeeds when it coincides with a pop. A pop on an empty
// FIFO is ignored and a coincident push is simply stored.
// Ports:
//   i_Clock, i_Reset       clock and async active-high reset
//   push, push_data        write request and sample to store at the tail
//   pop                    read request, removes the head when non-empty
//   pop_data               current head sample (valid when not empty)
//   full, empty, count     occupancy status
module sample_fifo
  import sample_output_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        push,
  input  sample_t                     push_data,
  input  logic                        pop,
  output sample_t                     pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  sample_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_COUNT);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // Pop is resolved first, so a full FIFO still accepts a push on a pop cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two; the count
  // cannot pass the depth since pushes are refused when full.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_output_serializer.sv
// sample_output_serializer
// Buffers mono samples from the sample generator and streams them at the
// fixed frame rate onto an I2S-style serial DAC link, duplicating each
// sample to left and right. Flags dropped samples and starved frames.
// Ports:
//   i_Clock, i_Reset   system clock, async active-high reset
//   i_SampleReady      one-cycle pulse qualifying i_Sample
//   i_Sample           signed 16-bit sample
//   i_ClearFlags       clears both sticky flags
//   o_BitClock         serial bit clock
//   o_WordSelect       0 = left, 1 = right (leads the MSB by one slot)
//   o_SerialData       serial data, MSB first
//   o_FifoCount        FIFO occupancy
//   o_Overflow         sticky: sample dropped on a full FIFO
//   o_Underflow        sticky: frame started with an empty FIFO
module sample_output_serializer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int BCLK_DIV     = 4,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_SampleReady,
  input  logic [SAMPLE_WIDTH-1:0]     i_Sample,
  input  logic                        i_ClearFlags,
  output logic                        o_BitClock,
  output logic                        o_WordSelect,
  output logic                        o_SerialData,
  output logic [$clog2(FIFO_DEPTH):0] o_FifoCount,
  output logic                        o_Overflow,
  output logic                        o_Underflow
);

  import sample_output_serializer_pkg::*;

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_count;
  slot_t            slot;
  slot_t            next_slot;
  sample_t          hold;
  sample_t          fifo_head;
  sample_t          frame_sample;
  logic             div_tick;
  logic             fall_edge;
  logic             frame_start;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow_set;
  logic             underflow_set;

  sample_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .push      (i_SampleReady),
    .push_data (sample_t'(i_Sample)),
    .pop       (frame_start),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_FifoCount)
  );

  assign div_tick    = (div_count == DIV_LAST);
  assign fall_edge   = div_tick & o_BitClock;
  assign frame_start = fall_edge & (slot == slot_t'(SLOTS_PER_FRAME - 1));
  assign next_slot   = slot + slot_t'(1);

  // On the frame boundary the new head is used directly so its MSB goes out
  // in the same cycle it is popped; a starved frame repeats the held sample.
  assign frame_sample = (frame_start && !fifo_empty) ? fifo_head : hold;

  // A full FIFO only drops when no pop frees a slot in the same cycle.
  assign overflow_set  = i_SampleReady & fifo_full & ~frame_start;
  assign underflow_set = frame_start & fifo_empty;

  // Bit clock generation and slot sequencing; data and word select change
  // together with the falling bit clock so the DAC samples them on the rise.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      div_count    <= '0;
      o_BitClock   <= 1'b0;
      slot         <= slot_t'(SLOTS_PER_FRAME - 1);
      hold         <= '0;
      o_SerialData <= 1'b0;
      o_WordSelect <= 1'b0;
    end else begin
      if (div_tick) begin
        div_count  <= '0;
        o_BitClock <= ~o_BitClock;
      end else begin
        div_count  <= div_count + DIV_W'(1);
      end
      if (fall_edge) begin
        slot         <= next_slot;
        o_WordSelect <= ws_for_slot(next_slot);
        o_SerialData <= frame_sample[bit_index(next_slot)];
        if (frame_start) begin
          hold <= frame_sample;
        end
      end
    end
  end

  // Sticky flags: a set event in the same cycle beats a clear request.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      if (overflow_set)      o_Overflow  <= 1'b1;
      else if (i_ClearFlags) o_Overflow  <= 1'b0;
      if (underflow_set)     o_Underflow <= 1'b1;
      else if (i_ClearFlags) o_Underflow <= 1'b0;
    end
  end

endmodule
